// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default constants for the FIFO write arbiter
package fifo_arb_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int N_REQ_DEF     = 4;
    localparam int BURST_MAX_DEF = 8;
    localparam int BEAT_W        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        STALL = 2'd2
    } arb_state_t;

    // Index width for a requester id; never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin winner search
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDW   = id_width(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic [IDW-1:0]   winner,
    output logic             found
);

    // Scan from last_grant+1 around to last_grant; walking the offsets downward
    // lets the closest requester overwrite any farther one.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (req[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding a single FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int N_REQ     = N_REQ_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                     clk_wr,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     flag_full,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wr_data,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     stall
);

    localparam int IDW = $clog2(N_REQ);

    arb_state_t        state;
    logic [IDW-1:0]    last_grant;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_cnt_nxt;

    logic [IDW-1:0]    pick_id;
    logic              pick_found;

    logic              cur_valid;
    logic              cur_last;
    logic [WIDTH-1:0]  cur_data;
    logic              beat;
    logic              burst_done;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (pick_id),
        .found      (pick_found)
    );

    // Select the granted requester's valid/last/data; other requesters are ignored.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign beat         = (state == BURST) && cur_valid && !flag_full;
    assign beat_cnt_nxt = beat_cnt + 8'd1;
    assign burst_done   = cur_last || (beat_cnt_nxt == 8'(BURST_MAX));

    assign wr_en        = beat;
    assign grant_valid  = (state != IDLE);
    assign stall        = (state == STALL);
    assign wr_data      = grant_valid ? cur_data : '0;

    // Only the granted requester sees ready, and only on a real beat.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = beat && (grant_id == IDW'(i));
        end
    end

    // Grant FSM: arbitrate in IDLE, stream in BURST, hold the grant in STALL.
    always_ff @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(N_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id   <= pick_id;
                        last_grant <= pick_id;
                        beat_cnt   <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (!cur_valid) begin
                        state <= IDLE;
                    end else if (flag_full) begin
                        state <= STALL;
                    end else begin
                        beat_cnt <= beat_cnt_nxt;
                        if (burst_done) begin
                            state <= IDLE;
                        end
                    end
                end
                STALL: begin
                    if (!flag_full) begin
                        state <= BURST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
